// File: rtl/ov7670_capture.sv
// ov7670_capture
//
// Captures an OV7670 RGB565 byte stream (high byte first) and writes it as
// RGB444 pixels into a linear, row-major frame buffer. The whole block runs
// on the camera pixel clock.
//
// Optional build macro:
//   OV7670_CAPTURE_FRAME_SKIP_EN - capture only every other frame, starting
//                                  with the first frame after reset.
//
// Ports:
//   i_clk        camera PCLK, all logic on the rising edge
//   i_rst        asynchronous active-high reset
//   i_cfg_done   high once the SCCB register load has finished
//   i_vsync      camera VSYNC, high during vertical blanking
//   i_href       camera HREF, high while line bytes are valid
//   i_data       camera D[7:0]
//   o_wr_en      frame-buffer write strobe, one cycle per pixel
//   o_wr_addr    linear pixel address, row-major from 0
//   o_wr_data    RGB444 pixel {R[3:0],G[3:0],B[3:0]}
//   o_frame_done one-cycle pulse at the end of each captured frame
//   o_busy       high while a frame is being captured
module ov7670_capture #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int ADDR_W  = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_done,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [11:0]       o_wr_data,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int unsigned       PIXELS    = FRAME_W * FRAME_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              vsync_prev_reg;
  logic              phase_reg;
  logic              full_reg;
  // Only the bits of the first byte that survive into RGB444: R[7:4] and G[2:0]
  logic [6:0]        byte0_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [11:0]       data_reg;
  logic              frame_done_reg;

  logic vs_fall;
  logic vs_rise;
  logic frame_start;
  logic frame_end;
  logic stay_capture;
  logic pixel_write;
  logic take_frame;

  assign vs_fall = vsync_prev_reg & ~i_vsync;
  assign vs_rise = ~vsync_prev_reg & i_vsync;

`ifdef OV7670_CAPTURE_FRAME_SKIP_EN
  // Toggles on every frame start seen while armed; frames are taken while it is 0.
  logic skip_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      skip_reg <= 1'b0;
    end else if (i_cfg_done && state_reg == WAIT_VS && vs_fall) begin
      skip_reg <= ~skip_reg;
    end
  end

  assign take_frame = ~skip_reg;
`else
  assign take_frame = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (!i_cfg_done) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = WAIT_VS;
        end
        WAIT_VS: begin
          if (vs_fall && take_frame) begin
            state_next  = CAPTURE;
            frame_start = 1'b1;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            state_next = WAIT_VS;
            frame_end  = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Bytes are only consumed on edges that keep us in CAPTURE, so a write can
  // never be registered on the same edge that leaves the state.
  assign stay_capture = (state_reg == CAPTURE) && (state_next == CAPTURE);
  assign pixel_write  = stay_capture && i_href && phase_reg && !full_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vsync_prev_reg <= 1'b0;
      phase_reg      <= 1'b0;
      full_reg       <= 1'b0;
      byte0_reg      <= '0;
      wr_en_reg      <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      vsync_prev_reg <= i_vsync;
      wr_en_reg      <= pixel_write;
      frame_done_reg <= frame_end;

      // Address advances the cycle after each write and parks on the last
      // location once the buffer is full.
      if (frame_start) begin
        addr_reg <= '0;
        full_reg <= 1'b0;
      end else if (wr_en_reg) begin
        if (addr_reg == LAST_ADDR) begin
          full_reg <= 1'b1;
        end else begin
          addr_reg <= addr_reg + 1'b1;
        end
      end

      // Any HREF gap drops a half-received pixel.
      if (stay_capture && i_href) begin
        phase_reg <= ~phase_reg;
        if (!phase_reg) begin
          byte0_reg <= {i_data[7:4], i_data[2:0]};
        end
      end else begin
        phase_reg <= 1'b0;
      end

      if (pixel_write) begin
        data_reg <= {byte0_reg, i_data[7], i_data[4:1]};
      end
    end
  end

  assign o_wr_en      = wr_en_reg;
  assign o_wr_addr    = addr_reg;
  assign o_wr_data    = data_reg;
  assign o_frame_done = frame_done_reg;
  assign o_busy       = (state_reg == CAPTURE);

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 Parameter FRAME_W, default 320, active pixels per line stored.
REQ-002 Parameter FRAME_H, default 240, lines per frame stored.
REQ-003 Parameter ADDR_W, default 17, frame-buffer address width; SHALL satisfy 2^ADDR_W >= FRAME_W*FRAME_H.
REQ-004 One clock; reset is asynchronous and active-high: ports i_clk and i_rst.
REQ-005 i_clk  input  1  camera PCLK; all logic on its rising edge.
REQ-006 i_rst  input  1  async active-high reset.
REQ-007 i_cfg_done  input  1  level from the SCCB configure stage; high once the camera register load is finished.
REQ-008 i_vsync  input  1  camera VSYNC, high during vertical blanking.
REQ-009 i_href  input  1  camera HREF, high while line bytes are valid.
REQ-010 i_data  input  8  camera D[7:0], RGB565 byte stream, high byte first.
REQ-011 o_wr_en  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-012 o_wr_addr  output  ADDR_W  linear pixel address, row-major from 0.
REQ-013 o_wr_data  output  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-014 o_frame_done  output  1  one-cycle pulse at the end of each captured frame.
REQ-015 o_busy  output  1  high in state CAPTURE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_VS and CAPTURE.
REQ-017 IDLE -> WAIT_VS when i_cfg_done=1; any state -> IDLE on the cycle i_cfg_done=0, with no further writes.
REQ-018 WAIT_VS -> CAPTURE on a registered falling edge of i_vsync (prev=1, now=0); o_wr_addr SHALL clear to 0 and the byte phase to 0 on that transition.
REQ-019 CAPTURE -> WAIT_VS on a rising edge of i_vsync; o_frame_done SHALL pulse high for exactly that one cycle.
REQ-020 In CAPTURE, each edge with i_href=1 samples i_data; phase 0 latches byte0 and sets phase 1; phase 1 forms the pixel and sets phase 0.
REQ-021 On the phase-1 edge, o_wr_en SHALL be registered high for one cycle with o_wr_data={byte0[7:4],byte0[2:0],i_data[7],i_data[4:1]} and the current o_wr_addr.
REQ-022 o_wr_addr SHALL increment by 1 in the cycle after each write.
REQ-023 Phase SHALL clear whenever i_href=0; a dangling byte0 at line end is discarded, with no write.
REQ-024 Writes SHALL be suppressed once FRAME_W*FRAME_H pixels are written in the frame; the address holds at FRAME_W*FRAME_H-1 and never wraps.
REQ-025 A frame ending early (vsync rise before the buffer is full) SHALL still pulse o_frame_done; the unwritten locations are left untouched.
REQ-026 o_wr_en SHALL never assert outside CAPTURE.

Reset
REQ-027 i_rst=1 SHALL immediately force state IDLE, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_frame_done=0, o_busy=0, phase=0, and the vsync history register to 0.
REQ-028 Reset mid-frame SHALL abandon the frame; after release, capture restarts only at the next vsync falling edge seen with i_cfg_done=1.

Configuration
REQ-029 Macro OV7670_CAPTURE_FRAME_SKIP_EN: when defined, a toggle flag SHALL let only alternate frames enter CAPTURE, starting with the first frame after reset, with no writes and no o_frame_done on skipped frames.
REQ-030 Without OV7670_CAPTURE_FRAME_SKIP_EN, every frame is captured and the toggle logic is absent.

Verification
REQ-031 Hold i_cfg_done=0 and drive a full frame -> o_wr_en stays 0, state IDLE.
REQ-032 With cfg_done=1, drive vsync 1->0 then one line of bytes 0xF8,0x00 -> one write, addr 0, data 0xF00; next pair 0x07,0xE0 -> addr 1, data 0x0F0.
REQ-033 Drive a line with HREF high for 3 bytes -> exactly one write; the next line's first pixel lands at the next address.
REQ-034 Drive a 320x240 frame plus 5 extra pixels -> 76800 writes, last addr 76799, then vsync rise -> o_frame_done pulses exactly once.
REQ-035 Assert i_rst mid-line at addr 1000 -> all outputs 0 the same cycle; after release, the next frame starts at addr 0.
REQ-036 With OV7670_CAPTURE_FRAME_SKIP_EN, drive 4 frames -> writes and o_frame_done occur on frames 1 and 3 only.
